// File: rtl/mcb_stream_writer.sv
// ----------------------------------------------------------------------------
// mcb_stream_writer
//
// Upstream feeder for MCB user port 0. Packs a 32-bit valid/ready word stream
// into bursts in the MCB write FIFO. It issues one WRITE command per burst and
// advances a byte address pointer that wraps inside [BASE_ADDR, BASE_ADDR+REGION_BYTES).
//
// Optional build macro: MCB_AUTO_PRECHARGE_EN
//   When defined, bursts are issued as WRITE with auto precharge (3'b010).
//   When undefined, bursts are issued as plain WRITE (3'b000).
//
// Ports
//   clk, rst           user clock; asynchronous active-low reset
//   calib_done         MCB calibration complete (sampled only while IDLE)
//   s_tdata/s_tvalid/s_tlast/s_tready
//                      input word stream; tlast flushes a partial burst
//   p0_cmd_*           MCB command port (en, instr, bl, byte_addr, full)
//   p0_wr_*            MCB write-data port (en, mask, data, full, empty,
//                      underrun, error)
//   busy               activity flag (low in IDLE and in an empty FILL)
//   err                sticky error flag; cleared only by reset
//   burst_cnt          number of commands issued, wraps at 2^32
// ----------------------------------------------------------------------------
module mcb_stream_writer #(
    parameter int          BURST_WORDS  = 32,
    parameter logic [29:0] BASE_ADDR    = 30'h0000_0000,
    parameter logic [29:0] REGION_BYTES = 30'h0010_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        calib_done,
    input  logic [31:0] s_tdata,
    input  logic        s_tvalid,
    input  logic        s_tlast,
    output logic        s_tready,
    output logic        p0_cmd_en,
    output logic [2:0]  p0_cmd_instr,
    output logic [5:0]  p0_cmd_bl,
    output logic [29:0] p0_cmd_byte_addr,
    input  logic        p0_cmd_full,
    output logic        p0_wr_en,
    output logic [3:0]  p0_wr_mask,
    output logic [31:0] p0_wr_data,
    input  logic        p0_wr_full,
    input  logic        p0_wr_empty,
    input  logic        p0_wr_underrun,
    input  logic        p0_wr_error,
    output logic        busy,
    output logic        err,
    output logic [31:0] burst_cnt
);

    localparam logic [6:0]  BURST_LEN  = 7'(BURST_WORDS);
    // Computed one bit wider so a region ending at the top of the address
    // space still compares correctly.
    localparam logic [30:0] REGION_END = {1'b0, BASE_ADDR} + {1'b0, REGION_BYTES};

`ifdef MCB_AUTO_PRECHARGE_EN
    localparam logic [2:0] WRITE_INSTR = 3'b010;
`else
    localparam logic [2:0] WRITE_INSTR = 3'b000;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_WAIT_CMD,
        S_ISSUE,
        S_DRAIN,
        S_ERROR
    } state_t;

    state_t      state_reg,     state_next;
    logic [6:0]  word_cnt_reg,  word_cnt_next;
    logic        wait_cnt_reg,  wait_cnt_next;
    logic [29:0] addr_ptr_reg,  addr_ptr_next;
    logic [31:0] burst_cnt_reg, burst_cnt_next;
    logic        err_reg,       err_next;
    logic        busy_reg,      busy_next;
    logic        cmd_en_reg,    cmd_en_next;
    logic [2:0]  cmd_instr_reg, cmd_instr_next;
    logic [5:0]  cmd_bl_reg,    cmd_bl_next;
    logic [29:0] cmd_addr_reg,  cmd_addr_next;
    logic        wr_en_reg,     wr_en_next;
    logic [31:0] wr_data_reg,   wr_data_next;

    logic        ready_int;
    logic        accept;
    logic        fault;
    logic [30:0] addr_sum;

    assign ready_int = (state_reg == S_FILL) && (word_cnt_reg < BURST_LEN) && !p0_wr_full;
    assign accept    = s_tvalid && ready_int;
    assign fault     = p0_wr_underrun || p0_wr_error;
    assign addr_sum  = {1'b0, addr_ptr_reg} + {22'd0, word_cnt_reg, 2'b00};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= S_IDLE;
            word_cnt_reg  <= '0;
            wait_cnt_reg  <= 1'b0;
            addr_ptr_reg  <= BASE_ADDR;
            burst_cnt_reg <= '0;
            err_reg       <= 1'b0;
            busy_reg      <= 1'b0;
            cmd_en_reg    <= 1'b0;
            cmd_instr_reg <= '0;
            cmd_bl_reg    <= '0;
            cmd_addr_reg  <= '0;
            wr_en_reg     <= 1'b0;
            wr_data_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            word_cnt_reg  <= word_cnt_next;
            wait_cnt_reg  <= wait_cnt_next;
            addr_ptr_reg  <= addr_ptr_next;
            burst_cnt_reg <= burst_cnt_next;
            err_reg       <= err_next;
            busy_reg      <= busy_next;
            cmd_en_reg    <= cmd_en_next;
            cmd_instr_reg <= cmd_instr_next;
            cmd_bl_reg    <= cmd_bl_next;
            cmd_addr_reg  <= cmd_addr_next;
            wr_en_reg     <= wr_en_next;
            wr_data_reg   <= wr_data_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        word_cnt_next  = word_cnt_reg;
        wait_cnt_next  = wait_cnt_reg;
        addr_ptr_next  = addr_ptr_reg;
        burst_cnt_next = burst_cnt_reg;
        err_next       = err_reg;
        cmd_en_next    = 1'b0;
        cmd_instr_next = cmd_instr_reg;
        cmd_bl_next    = cmd_bl_reg;
        cmd_addr_next  = cmd_addr_reg;
        wr_en_next     = 1'b0;
        wr_data_next   = wr_data_reg;

        case (state_reg)
            S_IDLE: begin
                if (calib_done) begin
                    state_next = S_FILL;
                end
            end
            S_FILL: begin
                if (accept) begin
                    wr_en_next    = 1'b1;
                    wr_data_next  = s_tdata;
                    word_cnt_next = word_cnt_reg + 7'd1;
                    // A tlast on the word that also fills the burst closes
                    // just this one burst.
                    if ((word_cnt_reg + 7'd1 == BURST_LEN) || s_tlast) begin
                        state_next    = S_WAIT_CMD;
                        wait_cnt_next = 1'b0;
                    end
                end
            end
            S_WAIT_CMD: begin
                // Two idle cycles so the final data push reaches the MCB
                // write FIFO before its command does.
                if (wait_cnt_reg) begin
                    state_next = S_ISSUE;
                end else begin
                    wait_cnt_next = 1'b1;
                end
            end
            S_ISSUE: begin
                if (!p0_cmd_full) begin
                    cmd_en_next    = 1'b1;
                    cmd_instr_next = WRITE_INSTR;
                    cmd_bl_next    = 6'(word_cnt_reg - 7'd1);
                    cmd_addr_next  = addr_ptr_reg;
                    // Any burst (full or partial) that reaches the region end
                    // sends the pointer back to the base.
                    if (addr_sum >= REGION_END) begin
                        addr_ptr_next = BASE_ADDR;
                    end else begin
                        addr_ptr_next = addr_sum[29:0];
                    end
                    burst_cnt_next = burst_cnt_reg + 32'd1;
                    word_cnt_next  = '0;
                    state_next     = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (p0_wr_empty) begin
                    state_next = S_FILL;
                end
            end
            S_ERROR: begin
            end
            default: begin
                state_next = S_ERROR;
            end
        endcase

        // A fault overrides the next state only; a command pulse already
        // decided this cycle still goes out.
        if ((state_reg != S_IDLE) && fault) begin
            err_next   = 1'b1;
            state_next = S_ERROR;
        end
    end

    assign busy_next = !((state_next == S_IDLE) ||
                         ((state_next == S_FILL) && (word_cnt_next == 7'd0)));

    assign s_tready         = ready_int;
    assign p0_cmd_en        = cmd_en_reg;
    assign p0_cmd_instr     = cmd_instr_reg;
    assign p0_cmd_bl        = cmd_bl_reg;
    assign p0_cmd_byte_addr = cmd_addr_reg;
    assign p0_wr_en         = wr_en_reg;
    assign p0_wr_mask       = 4'b0000;
    assign p0_wr_data       = wr_data_reg;
    assign busy             = busy_reg;
    assign err              = err_reg;
    assign burst_cnt        = burst_cnt_reg;

endmodule

// File: tb/tb_mcb_stream_writer.sv
// ----------------------------------------------------------------------------
// tb_mcb_stream_writer
//
// Scoreboard bench: stimulus tasks push expected write words and commands into
// queues; an independent monitor pops and compares whenever the DUT strobes
// p0_wr_en or p0_cmd_en. The DUT uses a 0x100-byte region so address wrap is
// reachable with 32-word bursts.
// ----------------------------------------------------------------------------
module tb_mcb_stream_writer;

    logic        clk;
    logic        rst;
    logic        calib_done;
    logic [31:0] s_tdata;
    logic        s_tvalid;
    logic        s_tlast;
    logic        s_tready;
    logic        p0_cmd_en;
    logic [2:0]  p0_cmd_instr;
    logic [5:0]  p0_cmd_bl;
    logic [29:0] p0_cmd_byte_addr;
    logic        p0_cmd_full;
    logic        p0_wr_en;
    logic [3:0]  p0_wr_mask;
    logic [31:0] p0_wr_data;
    logic        p0_wr_full;
    logic        p0_wr_empty;
    logic        p0_wr_underrun;
    logic        p0_wr_error;
    logic        busy;
    logic        err;
    logic [31:0] burst_cnt;

`ifdef MCB_AUTO_PRECHARGE_EN
    localparam logic [2:0] EXP_INSTR = 3'b010;
`else
    localparam logic [2:0] EXP_INSTR = 3'b000;
`endif

    mcb_stream_writer #(
        .BURST_WORDS (32),
        .BASE_ADDR   (30'h0),
        .REGION_BYTES(30'h100)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .calib_done      (calib_done),
        .s_tdata         (s_tdata),
        .s_tvalid        (s_tvalid),
        .s_tlast         (s_tlast),
        .s_tready        (s_tready),
        .p0_cmd_en       (p0_cmd_en),
        .p0_cmd_instr    (p0_cmd_instr),
        .p0_cmd_bl       (p0_cmd_bl),
        .p0_cmd_byte_addr(p0_cmd_byte_addr),
        .p0_cmd_full     (p0_cmd_full),
        .p0_wr_en        (p0_wr_en),
        .p0_wr_mask      (p0_wr_mask),
        .p0_wr_data      (p0_wr_data),
        .p0_wr_full      (p0_wr_full),
        .p0_wr_empty     (p0_wr_empty),
        .p0_wr_underrun  (p0_wr_underrun),
        .p0_wr_error     (p0_wr_error),
        .busy            (busy),
        .err             (err),
        .burst_cnt       (burst_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  bl;
        logic [29:0] addr;
        logic [31:0] cnt;
    } cmd_t;

    cmd_t        cmd_q[$];
    logic [31:0] wr_q[$];

    int checks   = 0;
    int errors   = 0;
    int wr_seen  = 0;
    int cmd_seen = 0;
    int run_len  = 0;
    int run_max  = 0;

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (p0_wr_en) begin
            wr_seen++;
            run_len++;
            if (run_len > run_max) run_max = run_len;
            checks++;
            if (wr_q.size() == 0) begin
                errors++;
                $display("FAIL wr_unexpected: got data=%08h, required no write", p0_wr_data);
            end else begin
                logic [31:0] exp_d;
                exp_d = wr_q.pop_front();
                if (p0_wr_data !== exp_d || p0_wr_mask !== 4'b0000) begin
                    errors++;
                    $display("FAIL wr_data: got %08h mask %h, required %08h mask 0",
                             p0_wr_data, p0_wr_mask, exp_d);
                end else begin
                    $display("wr   data=%08h", p0_wr_data);
                end
            end
        end else begin
            run_len = 0;
        end
        if (p0_cmd_en) begin
            cmd_seen++;
            checks++;
            if (cmd_q.size() == 0) begin
                errors++;
                $display("FAIL cmd_unexpected: got bl=%0d addr=%h, required no command",
                         p0_cmd_bl, p0_cmd_byte_addr);
            end else begin
                cmd_t e;
                e = cmd_q.pop_front();
                if (p0_cmd_instr !== EXP_INSTR || p0_cmd_bl !== e.bl ||
                    p0_cmd_byte_addr !== e.addr || burst_cnt !== e.cnt) begin
                    errors++;
                    $display("FAIL cmd: got instr=%0d bl=%0d addr=%h cnt=%0d, required instr=%0d bl=%0d addr=%h cnt=%0d",
                             p0_cmd_instr, p0_cmd_bl, p0_cmd_byte_addr, burst_cnt,
                             EXP_INSTR, e.bl, e.addr, e.cnt);
                end else begin
                    $display("cmd  instr=%0d bl=%0d addr=%h cnt=%0d",
                             p0_cmd_instr, p0_cmd_bl, p0_cmd_byte_addr, burst_cnt);
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp_v);
        end
    endtask

    task automatic push_cmd(input logic [5:0] bl, input logic [29:0] addr, input logic [31:0] cnt);
        cmd_t c;
        c.bl   = bl;
        c.addr = addr;
        c.cnt  = cnt;
        cmd_q.push_back(c);
    endtask

    task automatic send(input logic [31:0] d, input logic last);
        int n;
        n = 0;
        s_tdata  = d;
        s_tvalid = 1'b1;
        s_tlast  = last;
        while (!s_tready && n < 200) begin
            tick(1);
            n++;
        end
        if (!s_tready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: s_tready stayed 0, required 1 within 200 cycles");
        end else begin
            wr_q.push_back(d);
            tick(1);
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic send_burst(input logic [31:0] base, input int n, input logic tlast_end);
        for (int i = 0; i < n; i++) begin
            send(base + 32'(i), tlast_end && (i == n - 1));
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((wr_q.size() != 0 || cmd_q.size() != 0 || !s_tready) && n < 500) begin
            tick(1);
            n++;
        end
        checks++;
        if (n >= 500) begin
            errors++;
            $display("FAIL %s_timeout: pending wr=%0d cmd=%0d, required 0 within 500 cycles",
                     name, wr_q.size(), cmd_q.size());
        end
    endtask

    task automatic do_reset();
        calib_done = 1'b1;
        rst = 1'b0;
        tick(3);
        rst = 1'b1;
        tick(2);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int c0;
        int w0;
        rst            = 1'b0;
        calib_done     = 1'b0;
        s_tdata        = '0;
        s_tvalid       = 1'b0;
        s_tlast        = 1'b0;
        p0_cmd_full    = 1'b0;
        p0_wr_full     = 1'b0;
        p0_wr_empty    = 1'b1;
        p0_wr_underrun = 1'b0;
        p0_wr_error    = 1'b0;

        // Reset state
        tick(20);
        check("rst_tready", 32'(s_tready), 0);
        check("rst_cmd_en", 32'(p0_cmd_en), 0);
        check("rst_cmd_fields", {20'd0, p0_cmd_instr, p0_cmd_bl, 3'd0} | 32'(p0_cmd_byte_addr), 0);
        check("rst_wr_en", 32'(p0_wr_en), 0);
        check("rst_wr_data", p0_wr_data, 0);
        check("rst_wr_mask", 32'(p0_wr_mask), 0);
        check("rst_flags", {30'd0, busy, err}, 0);
        check("rst_burst_cnt", burst_cnt, 0);

        rst = 1'b1;
        tick(3);
        check("idle_tready_no_calib", 32'(s_tready), 0);
        calib_done = 1'b1;
        tick(1);
        check("fill_tready_after_calib", 32'(s_tready), 1);
        calib_done = 1'b0;   // ignored once out of IDLE
        check("fill_empty_not_busy", 32'(busy), 0);

        // Full burst with tlast on the filling word -> one command
        run_max = 0;
        push_cmd(6'd31, 30'h0, 32'd1);
        send_burst(32'h0, 32, 1'b1);
        check("burst_busy", 32'(busy), 1);
        wait_idle("burst1");
        check("zero_bubble_run", 32'(run_max), 32);
        check("burst_cnt_1", burst_cnt, 1);
        check("busy_after_drain", 32'(busy), 0);

        // Partial flush, then address progression and wrap
        do_reset();
        push_cmd(6'd4,  30'h000, 32'd1);
        send_burst(32'h100, 5, 1'b1);
        push_cmd(6'd31, 30'h014, 32'd2);
        send_burst(32'h200, 32, 1'b1);
        push_cmd(6'd31, 30'h094, 32'd3);   // 0x94+0x80 >= 0x100 -> wraps to 0
        send_burst(32'h300, 32, 1'b0);
        push_cmd(6'd0,  30'h000, 32'd4);   // single-word burst
        send_burst(32'h400, 1, 1'b1);
        wait_idle("partial");

        // Full bursts closing on count alone: 0x00, 0x80, 0x00
        do_reset();
        push_cmd(6'd31, 30'h00, 32'd1);
        push_cmd(6'd31, 30'h80, 32'd2);
        push_cmd(6'd31, 30'h00, 32'd3);
        send_burst(32'hA000, 32, 1'b0);
        send_burst(32'hB000, 32, 1'b0);
        send_burst(32'hC000, 32, 1'b0);
        wait_idle("wrap");

        // Command FIFO back-pressure and drain hold-off
        do_reset();
        p0_cmd_full = 1'b1;
        c0 = cmd_seen;
        push_cmd(6'd3, 30'h0, 32'd1);
        send_burst(32'hD000, 4, 1'b1);
        tick(12);
        check("cmd_full_no_pulse", 32'(cmd_seen - c0), 0);
        check("cmd_full_busy", 32'(busy), 1);
        p0_wr_empty = 1'b0;
        p0_cmd_full = 1'b0;
        tick(1);
        check("cmd_release_pulse", 32'(cmd_seen - c0), 1);
        tick(5);
        check("cmd_single_pulse", 32'(cmd_seen - c0), 1);
        check("drain_tready_low", 32'(s_tready), 0);
        p0_wr_empty = 1'b1;
        tick(1);
        check("drain_done_tready", 32'(s_tready), 1);

        // Underrun mid-FILL -> sticky error, no further activity
        do_reset();
        send_burst(32'hE000, 3, 1'b0);
        tick(1);
        p0_wr_underrun = 1'b1;
        tick(1);
        p0_wr_underrun = 1'b0;
        check("err_set", 32'(err), 1);
        check("err_tready_low", 32'(s_tready), 0);
        w0 = wr_seen;
        c0 = cmd_seen;
        s_tvalid = 1'b1;
        s_tlast  = 1'b1;
        tick(100);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        check("err_no_writes", 32'(wr_seen - w0), 0);
        check("err_no_cmds", 32'(cmd_seen - c0), 0);
        check("err_sticky", 32'(err), 1);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_err", 32'(err), 0);
        check("async_rst_busy", 32'(busy), 0);
        tick(2);
        rst = 1'b1;
        tick(2);
        check("post_rst_tready", 32'(s_tready), 1);

        check("queues_empty", 32'(wr_q.size() + cmd_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mcb_stream_writer.md
Name: mcb_stream_writer

Overview:
- Upstream feeder for MCB user port 0 on the Atlys DDR path.
- Accepts a 32-bit valid/ready word stream and packs it into bursts in the MCB write FIFO.
- Issues one WRITE command per burst and advances a wrapping byte address pointer.
- Lets the DDR test/readback logic consume stream-captured data at known addresses.

Parameters:
- BURST_WORDS, 32, words per full burst; legal range 1..64.
- BASE_ADDR, 30'h0000_0000, first byte address of the write region; must be 4-byte aligned.
- REGION_BYTES, 30'h0010_0000, region size in bytes; must be a multiple of BURST_WORDS*4.

Ports:
- clk  in  1  system/MCB user clock.
- rst  in  1  reset, asynchronous, active-low.
- calib_done  in  1  MCB calibration complete.
- s_tdata  in  32  stream data word.
- s_tvalid  in  1  stream word valid.
- s_tlast  in  1  last word of packet; flushes a partial burst.
- s_tready  out  1  stream ready.
- p0_cmd_en  out  1  command strobe, one-cycle pulse.
- p0_cmd_instr  out  3  MCB instruction.
- p0_cmd_bl  out  6  burst length minus 1.
- p0_cmd_byte_addr  out  30  burst start byte address.
- p0_cmd_full  in  1  MCB command FIFO full.
- p0_wr_en  out  1  write FIFO push.
- p0_wr_mask  out  4  byte mask; always 4'b0000.
- p0_wr_data  out  32  write FIFO data.
- p0_wr_full  in  1  write FIFO full.
- p0_wr_empty  in  1  write FIFO empty.
- p0_wr_underrun  in  1  MCB write underrun.
- p0_wr_error  in  1  MCB write error.
- busy  out  1  high in any state other than IDLE or FILL with word_cnt==0.
- err  out  1  sticky error flag.
- burst_cnt  out  32  number of commands issued; wraps at 2^32.

Behaviour:
- Reset (rst low, async): state=IDLE. All outputs are 0. addr_ptr=BASE_ADDR. word_cnt=0.
- Port outputs are registered, except s_tready, which is combinational from state, word_cnt and p0_wr_full.
- IDLE: move to FILL when calib_done=1. calib_done is sampled only in IDLE; a later deassertion is ignored.
- FILL:
  - s_tready = (word_cnt < BURST_WORDS) && !p0_wr_full.
  - On each s_tvalid&&s_tready: next cycle p0_wr_en=1 and p0_wr_data=s_tdata; word_cnt++.
  - Zero-bubble: back-to-back words each produce a wr_en on consecutive cycles.
  - Burst closes when the accepted word makes word_cnt==BURST_WORDS, or when s_tlast is accepted. Then go to WAIT_CMD.
- WAIT_CMD: hold 2 cycles so the last wr_en lands in the MCB FIFO before the command, then go to ISSUE. p0_wr_en=0.
- ISSUE:
  - Wait while p0_cmd_full=1.
  - When clear: pulse p0_cmd_en for exactly 1 cycle, with instr=3'b000 (WRITE), bl=word_cnt-1, byte_addr=addr_ptr.
  - addr_ptr += word_cnt*4. If the result is >= BASE_ADDR+REGION_BYTES, addr_ptr=BASE_ADDR (a partial burst also wraps to base).
  - burst_cnt++; word_cnt=0; go to DRAIN.
- DRAIN: wait for p0_wr_empty=1, then go to FILL. This guarantees ≤64 words in the MCB FIFO.
- Error: p0_wr_underrun or p0_wr_error high in any non-IDLE state sets err=1. State goes to ERROR, where s_tready=0, no further commands are issued, and the block stays until reset.
- Simultaneous events:
  - s_tlast accepted with word_cnt reaching BURST_WORDS: one burst only.
  - Error on the same cycle as an ISSUE pulse: the pulse completes, then ERROR.
- A tlast-only flush with word_cnt==0 is impossible, because tlast is only acted on when a word is accepted.

Optional Feature:
- Macro: MCB_AUTO_PRECHARGE_EN.
- Defined: ISSUE uses p0_cmd_instr=3'b010 (WRITE with auto precharge).
- Undefined: p0_cmd_instr=3'b000.
- Everything else is identical.

Test Plan:
- Reset low, calib_done=0 for 20 cycles -> s_tready=0, all outputs 0. Assert calib_done -> s_tready=1 next cycle.
- 32 back-to-back words 0..31, tlast on word 31 -> 32 consecutive wr_en with matching data. Then one cmd_en with instr=0, bl=31, addr=0x0. burst_cnt=1.
- 5 words, tlast on the 5th -> cmd bl=4, addr=0x0. Next full burst has addr=0x14.
- Set REGION_BYTES=0x100 and stream 3 full bursts -> addresses 0x00, 0x80, 0x00.
- Hold p0_cmd_full=1 for 10 cycles during ISSUE -> no cmd_en. Exactly 1 pulse after release. s_tready stays 0 until p0_wr_empty.
- Pulse p0_wr_underrun mid-FILL -> err=1, s_tready=0, no cmd_en for 100 cycles. Async reset clears err.
